osc_meas_scheduler: RTL
=======================

Name: osc_meas_scheduler

Overview:
Measurement sequencer for the ring-oscillator temperature sensor datapath. It arbitrates between two requesters (inverter-chain and NAND4 oscillator measurements) and powers up the granted oscillator. It then sequences a settle period, counter clear, a fixed gate window and a drain/capture phase. The captured count is delivered through a valid/ready handshake to the averaging and UART send logic.

Parameters:
WIDTH, 16, width of the oscillator counter and result
WINDOW, 1000, gate length in clk cycles with cnt_en high (>=1)
SETTLE, 16, cycles the oscillator runs with counter held clear before gating (>=1)

Ports:
clk  in  1  system clock (clk_in domain)
rst  in  1  synchronous reset, active-high
req_inv  in  1  level request: measure inverter ring oscillator (id 0)
req_nand  in  1  level request: measure NAND4 ring oscillator (id 1)
count  in  WIDTH  oscillator counter value
osc_en_inv  out  1  enable for inverter oscillator
osc_en_nand  out  1  enable for NAND4 oscillator
osc_sel  out  1  mux select = id of current grant
cnt_clr  out  1  counter synchronous clear
cnt_en  out  1  counter gate
result  out  WIDTH  captured count
result_id  out  1  oscillator id of result
result_sat  out  1  captured count was all-ones
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all outputs 0; last_id <= 1 so the first contended grant goes to id 0. Reset mid-operation aborts immediately; oscillators are disabled the cycle after.
- States: IDLE -> SETTLE -> GATE -> DRAIN -> OUTPUT -> IDLE.
- IDLE: all enables low. If req_inv or req_nand is high, latch id and go to SETTLE.
  - One request: grant that requester.
  - Both requests: grant the id != last_id (round-robin); last_id <= granted id.
- SETTLE, SETTLE cycles: osc_en of the granted id high; cnt_clr=1; cnt_en=0.
- GATE, WINDOW cycles: osc_en high, cnt_clr=0, cnt_en=1.
- DRAIN, 2 cycles: osc_en high, cnt_en=0, which lets the counter synchronizer settle. On the last DRAIN cycle: result<=count, result_sat<=(count=={WIDTH{1}}), result_id<=id.
- OUTPUT: result_valid=1; osc_en both low; osc_sel holds id.
  - result, result_id and result_sat stay stable while result_valid is high.
  - Transfer occurs on a cycle with result_valid&&result_ready. result_valid is 0 from the next cycle and the state returns to IDLE.
- Latency: with the request sampled in IDLE at cycle N, result_valid is first high at cycle N+1+SETTLE+WINDOW+2.
- result_ready held high: back-to-back measurements are separated by exactly one IDLE cycle.
- Requests are levels and are ignored outside IDLE. Dropping a request mid-measurement does not abort it.
- result_ready while result_valid is low has no effect.
- At most one osc_en is high at any time. cnt_en and cnt_clr are never high together.
- Counters: phase counter width is clog2(max(WINDOW,SETTLE)). It is reloaded on each state entry, so there is no wrap-around across states.

Test Plan:
- WINDOW=8, SETTLE=2; rst then req_inv=1 one cycle at N -> osc_en_inv high N+1..N+12; cnt_clr high N+1..N+2; cnt_en high N+3..N+10; result_valid at N+13, result_id=0.
- req_inv=req_nand=1 continuously, result_ready=1 -> result_id sequence 0,1,0,1; osc_en_inv and osc_en_nand never high together; one IDLE cycle between results.
- count forced to 16'hFFFF during DRAIN -> result_sat=1, result=16'hFFFF; a following count of 16'h1234 gives result_sat=0.
- result_ready=0 for 20 cycles after valid -> result_valid, result and result_id stable and both osc_en low. Asserting ready gives one transfer, valid low next cycle, busy low.
- rst asserted mid-GATE -> next cycle all outputs 0, state IDLE. A subsequent req_nand alone is granted id 1.
- req_nand pulsed only during GATE of an inverter measurement -> ignored, no second measurement starts.

Source files
------------

// File: rtl/osc_meas_scheduler_if.sv
// ---------------------------------------------------------------------------
// osc_meas_scheduler_if
// Result stream from the measurement sequencer to the averaging / UART logic.
//
// Handshake: result_valid is driven by the master and stays high, with result,
// result_id and result_sat held stable, until the slave asserts result_ready.
// A transfer happens on any clock edge where result_valid && result_ready.
// result_ready while result_valid is low has no effect.
//
// Signals:
//   result        [WIDTH] captured oscillator count
//   result_id             oscillator id (0 = inverter chain, 1 = NAND4)
//   result_sat            captured count was all-ones (counter saturated)
//   result_valid          result available
//   result_ready          consumer accepts the result
// ---------------------------------------------------------------------------
interface osc_meas_scheduler_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] result;
   logic             result_id;
   logic             result_sat;
   logic             result_valid;
   logic             result_ready;

   modport master (
      output result,
      output result_id,
      output result_sat,
      output result_valid,
      input  result_ready
   );

   modport slave (
      input  result,
      input  result_id,
      input  result_sat,
      input  result_valid,
      output result_ready
   );
endinterface

// File: rtl/osc_meas_scheduler.sv
// ---------------------------------------------------------------------------
// osc_meas_scheduler
// Measurement sequencer for the ring-oscillator temperature sensor. Picks one
// of two level requesters (round-robin when both are asking), powers up that
// oscillator, holds the counter clear for SETTLE cycles, gates the counter for
// WINDOW cycles, waits 2 drain cycles for the counter synchronizer, captures
// the count and offers it on the result stream.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   req_inv      level request, inverter ring oscillator (id 0)
//   req_nand     level request, NAND4 ring oscillator (id 1)
//   count        oscillator counter value
//   osc_en_inv   enable for the inverter oscillator
//   osc_en_nand  enable for the NAND4 oscillator
//   osc_sel      mux select, id of the current grant
//   cnt_clr      counter synchronous clear
//   cnt_en       counter gate
//   busy         high in every state except IDLE
//   dbg_state    current FSM state encoding (IDLE=0 .. OUTPUT=4)
//   res          result stream (master side)
// ---------------------------------------------------------------------------
module osc_meas_scheduler #(
   parameter int WIDTH  = 16,
   parameter int WINDOW = 1000,
   parameter int SETTLE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_inv,
   input  logic             req_nand,
   input  logic [WIDTH-1:0] count,
   output logic             osc_en_inv,
   output logic             osc_en_nand,
   output logic             osc_sel,
   output logic             cnt_clr,
   output logic             cnt_en,
   output logic             busy,
   output logic [2:0]       dbg_state,
   osc_meas_scheduler_if.master res
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_GATE   = 3'd2,
      S_DRAIN  = 3'd3,
      S_OUTPUT = 3'd4
   } state_t;

   // The phase counter only ever holds "cycles remaining - 1" of the longest
   // phase; keep at least one bit so the 2-cycle drain load fits.
   localparam int MAXC = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
   localparam logic [CW-1:0] WINDOW_LD = CW'(WINDOW - 1);
   localparam logic [CW-1:0] DRAIN_LD  = CW'(1);

   state_t          state;
   logic [CW-1:0]   phase;
   logic            id;
   logic            last_id;
   logic            grant_id;

   // With both requesters asking, hand the grant to the one not served last.
   always_comb begin
      grant_id = req_nand;
      if (req_inv && req_nand) begin
         grant_id = ~last_id;
      end
   end

   assign osc_sel   = id;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         phase            <= '0;
         id               <= 1'b0;
         last_id          <= 1'b1;
         osc_en_inv       <= 1'b0;
         osc_en_nand      <= 1'b0;
         cnt_clr          <= 1'b0;
         cnt_en           <= 1'b0;
         busy             <= 1'b0;
         res.result       <= '0;
         res.result_id    <= 1'b0;
         res.result_sat   <= 1'b0;
         res.result_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_inv || req_nand) begin
                  id          <= grant_id;
                  last_id     <= grant_id;
                  osc_en_inv  <= ~grant_id;
                  osc_en_nand <= grant_id;
                  cnt_clr     <= 1'b1;
                  busy        <= 1'b1;
                  phase       <= SETTLE_LD;
                  state       <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (phase == '0) begin
                  cnt_clr <= 1'b0;
                  cnt_en  <= 1'b1;
                  phase   <= WINDOW_LD;
                  state   <= S_GATE;
               end else begin
                  phase <= phase - CW'(1);
               end
            end
            S_GATE: begin
               if (phase == '0) begin
                  cnt_en <= 1'b0;
                  phase  <= DRAIN_LD;
                  state  <= S_DRAIN;
               end else begin
                  phase <= phase - CW'(1);
               end
            end
            S_DRAIN: begin
               // Oscillator keeps running while the counter synchronizer
               // catches up; the count is taken at the end of the last cycle.
               if (phase == '0) begin
                  res.result       <= count;
                  res.result_sat   <= &count;
                  res.result_id    <= id;
                  res.result_valid <= 1'b1;
                  osc_en_inv       <= 1'b0;
                  osc_en_nand      <= 1'b0;
                  state            <= S_OUTPUT;
               end else begin
                  phase <= phase - CW'(1);
               end
            end
            S_OUTPUT: begin
               if (res.result_ready) begin
                  res.result_valid <= 1'b0;
                  busy             <= 1'b0;
                  state            <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
